// File: rtl/prog_loader_pkg.sv
// loader_pkg: shared types and default sizing for the program loader.
// The width defaults match the core's fetch/ROM sizing so both sides agree
// on instruction width, address width and cycle-counter width.
package loader_pkg;

  localparam int INST_W_DEF = 10;
  localparam int ADDR_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DONE,
    S_ERR
  } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: host load stream, instruction-memory write port and core
// run-control signals bundled for prog_loader.
//   slave  : the loader's view (consumes the load stream and Halt, drives the
//            write port, Start and status).
//   master : the host/core view (drives the load stream and Halt).
interface prog_loader_if
  import loader_pkg::*;
#(
  parameter int INST_W = INST_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();
  logic              LoadValid;
  logic              LoadReady;
  logic [INST_W-1:0] LoadWord;
  logic              LoadLast;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [INST_W-1:0] WrData;
  logic              Start;
  logic              Halt;
  logic              Busy;
  logic              Done;
  logic              Error;
  logic [CNT_W-1:0]  CycleCount;

  modport slave (
    input  LoadValid, LoadWord, LoadLast, Halt,
    output LoadReady, WrEn, WrAddr, WrData, Start, Busy, Done, Error, CycleCount
  );

  modport master (
    output LoadValid, LoadWord, LoadLast, Halt,
    input  LoadReady, WrEn, WrAddr, WrData, Start, Busy, Done, Error, CycleCount
  );
endinterface

// File: rtl/prog_loader_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   clr_i  : synchronous clear (wins over en_i)
//   en_i   : count enable
//   cnt_o  : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)                 cnt_q <= '0;
    else if (clr_i)              cnt_q <= '0;
    else if (en_i && !(&cnt_q))  cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams instruction words into the core's instruction memory
// from address 0, then pulses Start and times the run until Halt.
//   CLK  : clock, rising edge
//   RSTn : synchronous active-low reset
//   bus  : prog_loader_if.slave -- load stream (LoadValid/Ready/Word/Last),
//          memory write port (WrEn/WrAddr/WrData), run control (Start/Halt)
//          and status (Busy/Done/Error/CycleCount)
module prog_loader
  import loader_pkg::*;
#(
  parameter int INST_W       = INST_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int START_CYCLES = 1,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic          CLK,
  input  logic          RSTn,
  prog_loader_if.slave  bus
);
  localparam int SC_W = (START_CYCLES < 1) ? 1 : $clog2(START_CYCLES + 1);

  loader_state_t     state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [INST_W-1:0] wr_data_q;
  logic [SC_W-1:0]   sc_q, sc_d;
  logic              ready_q, start_q, busy_q, done_q, error_q;

  logic              accept, from_new, cnt_en, cnt_clr;
  logic [ADDR_W-1:0] addr_cur;

  assign accept   = bus.LoadValid & ready_q;
  // A fresh program (from IDLE or after a finished run) restarts at address 0.
  assign from_new = (state_q == S_IDLE) || (state_q == S_DONE);
  assign addr_cur = from_new ? '0 : ptr_q;
  assign sc_d     = sc_q + 1'b1;
  assign cnt_clr  = accept & (state_q == S_DONE);
  assign cnt_en   = (state_q == S_RUN) & ~bus.Halt;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sc_q      <= '0;
      ready_q   <= 1'b1;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q <= addr_cur;
        wr_data_q <= bus.LoadWord;
      end

      unique case (state_q)
        S_IDLE, S_LOAD, S_DONE: begin
          if (accept) begin
            done_q <= 1'b0;
            if (bus.LoadLast) begin
              state_q <= S_START;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
              sc_q    <= '0;
            end else if (&addr_cur) begin
              // Memory full and no end marker: the word is still written.
              state_q <= S_ERR;
              ready_q <= 1'b0;
              error_q <= 1'b1;
            end else begin
              state_q <= S_LOAD;
              ptr_q   <= addr_cur + 1'b1;
            end
          end
        end
        // First START cycle carries the final write with Start low, so Start
        // never overlaps WrEn; Start then stays high for START_CYCLES cycles.
        // Halt is not looked at here since it may be stale from a prior run.
        S_START: begin
          if (sc_q == SC_W'(START_CYCLES)) begin
            state_q <= S_RUN;
            start_q <= 1'b0;
          end else begin
            sc_q    <= sc_d;
            start_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.Halt) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        S_ERR: begin
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Counts RUN cycles with Halt low; the halt cycle itself is not counted.
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk_i  (CLK),
    .rst_ni (RSTn),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (bus.CycleCount)
  );

  assign bus.LoadReady = ready_q;
  assign bus.WrEn      = wr_en_q;
  assign bus.WrAddr    = wr_addr_q;
  assign bus.WrData    = wr_data_q;
  assign bus.Start     = start_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Error     = error_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader. Accepted words push the
// expected write (address, data, cycle) into a queue; a negedge monitor pops
// and compares each write. Status outputs are checked at fixed cycle offsets.
module tb_prog_loader;
  import loader_pkg::*;

  localparam int IW = 10;
  localparam int AW = 8;
  localparam int CW = 16;
  localparam int SC = 1;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  prog_loader_if #(.INST_W(IW), .ADDR_W(AW), .CNT_W(CW)) bus ();

  prog_loader #(.INST_W(IW), .ADDR_W(AW), .START_CYCLES(SC), .CNT_W(CW)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
    int            cyc;
  } wr_exp_t;

  wr_exp_t sb[$];
  int cyc = 0;
  int nchk = 0, nerr = 0;
  int start_first = -1, start_n = 0;
  int exp_ptr = 0;
  int nwr = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Write/Start monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (RSTn) begin
      if (bus.WrEn) begin
        wr_exp_t e;
        nwr++;
        if (sb.size() == 0) chk("wr_unexpected", 32'(sb.size()), 1);
        else begin
          e = sb.pop_front();
          chk("wr_addr", 32'(bus.WrAddr), 32'(e.addr));
          chk("wr_data", 32'(bus.WrData), 32'(e.data));
          chk("wr_cyc",  cyc, e.cyc);
        end
      end
      if (bus.Start) begin
        if (start_first < 0) start_first = cyc;
        start_n++;
        chk("start_overlaps_wr", 32'(bus.WrEn), 0);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic idle();
    bus.LoadValid = 1'b0;
    bus.LoadWord  = IW'($urandom);
    bus.LoadLast  = 1'($urandom);
  endtask

  // Present one word; returns k = the cycle in which it was accepted.
  task automatic send(input logic [IW-1:0] w, input logic last, output int k);
    wr_exp_t e;
    bus.LoadValid = 1'b1;
    bus.LoadWord  = w;
    bus.LoadLast  = last;
    k = -1;
    for (int t = 0; t < 20; t++) begin
      if (bus.LoadReady) begin
        k = cyc;
        e.addr = AW'(exp_ptr);
        e.data = w;
        e.cyc  = k + 1;
        sb.push_back(e);
        exp_ptr++;
        step();
        return;
      end
      step();
    end
    chk("send_timeout", 32'(bus.LoadReady), 1);
  endtask

  task automatic check_reset(input string p);
    chk({p, "_ready"}, 32'(bus.LoadReady), 1);
    chk({p, "_wren"},  32'(bus.WrEn), 0);
    chk({p, "_waddr"}, 32'(bus.WrAddr), 0);
    chk({p, "_wdata"}, 32'(bus.WrData), 0);
    chk({p, "_start"}, 32'(bus.Start), 0);
    chk({p, "_busy"},  32'(bus.Busy), 0);
    chk({p, "_done"},  32'(bus.Done), 0);
    chk({p, "_error"}, 32'(bus.Error), 0);
    chk({p, "_cnt"},   32'(bus.CycleCount), 0);
  endtask

  task automatic new_prog();
    exp_ptr     = 0;
    start_first = -1;
    start_n     = 0;
  endtask

  initial begin
    int k, k1, k2, nwr0;
    bus.LoadValid = 1'b0;
    bus.LoadWord  = '0;
    bus.LoadLast  = 1'b0;
    bus.Halt      = 1'b0;
    RSTn = 1'b0;
    step();
    step();
    check_reset("rst");
    RSTn = 1'b1;

    // 3-word program, back-to-back, then halt 37 cycles after Start falls.
    new_prog();
    send(10'h001, 1'b0, k);
    send(10'h2A5, 1'b0, k);
    send(10'h3FF, 1'b1, k);
    idle();
    chk("t1_ready_start", 32'(bus.LoadReady), 0);
    chk("t1_busy_start",  32'(bus.Busy), 1);
    wait_cyc(k + 40);  // RUN begins at k+3, so this is 37 RUN cycles in
    chk("t1_start_cyc", start_first, k + 2);
    chk("t1_start_n",   start_n, 1);
    chk("t1_cnt_pre",   32'(bus.CycleCount), 37);
    chk("t1_busy_run",  32'(bus.Busy), 1);
    chk("t1_done_pre",  32'(bus.Done), 0);
    bus.Halt = 1'b1;
    step();
    chk("t1_done",  32'(bus.Done), 1);
    chk("t1_busy",  32'(bus.Busy), 0);
    chk("t1_cnt",   32'(bus.CycleCount), 37);
    chk("t1_ready", 32'(bus.LoadReady), 1);
    bus.Halt = 1'b0;
    step();
    step();
    chk("t1_cnt_frozen", 32'(bus.CycleCount), 37);
    chk("t1_done_sticky", 32'(bus.Done), 1);

    // Reload from DONE with a valid gap; then reset during RUN at count 10.
    new_prog();
    nwr0 = nwr;
    send(10'h155, 1'b0, k1);
    chk("t6_done_clr", 32'(bus.Done), 0);
    chk("t6_cnt_clr",  32'(bus.CycleCount), 0);
    chk("t6_wren",     32'(bus.WrEn), 1);
    chk("t6_waddr",    32'(bus.WrAddr), 0);
    idle();
    step();
    chk("t2_ready_gap", 32'(bus.LoadReady), 1);
    send(10'h0AA, 1'b1, k2);
    idle();
    wait_cyc(k2 + 13);
    chk("t2_nwr",     nwr - nwr0, 2);
    chk("t2_start_n", start_n, 1);
    chk("t5_cnt10",   32'(bus.CycleCount), 10);
    chk("t5_busy",    32'(bus.Busy), 1);
    RSTn = 1'b0;
    step();
    check_reset("t5");
    RSTn = 1'b1;

    // Reload after reset with Halt already high: zero-length run.
    new_prog();
    bus.Halt = 1'b1;
    send(10'h2C3, 1'b0, k);
    chk("t5_reload_addr", 32'(bus.WrAddr), 0);
    send(10'h13C, 1'b1, k);
    idle();
    wait_cyc(k + 6);
    chk("t7_done",    32'(bus.Done), 1);
    chk("t7_cnt0",    32'(bus.CycleCount), 0);
    chk("t7_busy",    32'(bus.Busy), 0);
    chk("t7_start_n", start_n, 1);
    bus.Halt = 1'b0;

    // 256 words without LoadLast: overflow into ERR, no Start.
    new_prog();
    nwr0 = nwr;
    for (int i = 0; i < 256; i++) send(IW'(i * 37 + 5), 1'b0, k);
    idle();
    step();
    step();
    chk("t4_nwr",     nwr - nwr0, 256);
    chk("t4_lastaddr", 32'(bus.WrAddr), 32'hFF);
    chk("t4_error",   32'(bus.Error), 1);
    chk("t4_ready",   32'(bus.LoadReady), 0);
    chk("t4_busy",    32'(bus.Busy), 0);
    nwr0 = nwr;
    bus.LoadValid = 1'b1;
    step();
    step();
    step();
    idle();
    step();
    chk("t4_no_wr_err", nwr - nwr0, 0);
    chk("t4_start_n",   start_n, 0);
    chk("t4_error_sticky", 32'(bus.Error), 1);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
